register_bank_mp: RTL and testbench
===================================

Name: register_bank_mp

Overview:
- Next-generation register bank for the MIPS datapath: parametrised width and depth, two write ports, two read ports.
- Supports optional write-to-read bypass and hard-wired register 0.
- Carries a per-register pending (busy) scoreboard that the pipeline control uses to detect load-use and multi-cycle hazards.
- Sits between the decode stage (reads, reservations) and the writeback stage (writes, releases).

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH.
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports combinationally; 0 = visible only after the clock edge.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and reservations; 0 = register 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- write_a  in  1  write enable, port A (ALU writeback).
- write_address_a  in  ADDR_WIDTH  write address, port A.
- write_data_a  in  DATA_WIDTH  write data, port A.
- write_b  in  1  write enable, port B (memory/load writeback).
- write_address_b  in  ADDR_WIDTH  write address, port B.
- write_data_b  in  DATA_WIDTH  write data, port B.
- reserve  in  1  mark reserve_address as pending.
- reserve_address  in  ADDR_WIDTH  register to reserve.
- read_address_1  in  ADDR_WIDTH  read address, port 1.
- read_address_2  in  ADDR_WIDTH  read address, port 2.
- read_data_1  out  DATA_WIDTH  read data, port 1.
- read_data_2  out  DATA_WIDTH  read data, port 2.
- read_busy_1  out  1  pending flag of read_address_1.
- read_busy_2  out  1  pending flag of read_address_2.
- any_busy  out  1  OR of all pending flags.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (rst_n low, at any time including mid-write):
  - All registers clear to 0 and all busy flags clear to 0 immediately.
  - Read data is 0, read_busy_* is 0 and any_busy is 0 while rst_n is low, regardless of BYPASS.
  - Writes and reservations are ignored while rst_n is low.
  - First update after release is on the first rising edge with rst_n high.
- Writes:
  - On the rising edge, write_x=1 stores write_data_x into registers[write_address_x].
  - If ZERO_REG=1 and the address is 0, the write is dropped.
  - If both ports write the same address in the same cycle, port B wins and port A's data is discarded.
- Reads (combinational, zero latency):
  - read_data_n = registers[read_address_n].
  - If BYPASS=1 and an enabled write port targets read_address_n this cycle (non-zero when ZERO_REG=1), read_data_n is that port's write data. Priority is port B, then port A, then storage.
  - If ZERO_REG=1, read address 0 always returns 0.
- Scoreboard (one busy bit per register):
  - Set: on the rising edge, reserve=1 sets busy[reserve_address].
  - Clear: on the rising edge, any write (A or B) clears busy[write_address].
  - Set and clear on the same address in the same edge: set wins, because the new pending producer supersedes the old one.
  - Reserving an already-busy register leaves it busy (no counting).
  - Writing a non-busy register is legal; busy stays 0.
  - ZERO_REG=1: busy[0] is never set.
- Busy outputs:
  - read_busy_n = busy[read_address_n], registered state only.
  - If BYPASS=1 and a write to read_address_n occurs this cycle without a same-address reserve, read_busy_n reads 0 (the data is being delivered now).
  - any_busy reflects registered state only (no bypass).
- Width rules: no truncation or extension. Addresses are always in range because depth = 2**ADDR_WIDTH.

Decomposition:
- Shared package regbank_pkg:
  - Default constants REG_DATA_WIDTH=32, REG_ADDR_WIDTH=5.
  - Constant ZERO_ADDR=0.
  - Typedef for a register-address type.
- One sub-module, regbank_scoreboard:
  - Parametrised by ADDR_WIDTH and ZERO_REG.
  - Holds the busy vector; takes the reserve and the two write-clear requests plus the two read addresses.
  - Outputs the raw busy bits for the read addresses and any_busy.
- The top adds the storage array, write-port priority and the bypass muxes.

Test Plan:
- Reset and basic write/read: assert rst_n=0 then release; write_a to addr 5 = 0x0000_00AA → read_address_1=5 returns 0xAA next cycle. Pulse rst_n=0 mid-cycle → read_data_1=0 immediately, without a clock edge.
- Write collision: write_a addr 7 = 0x1111_1111 and write_b addr 7 = 0x2222_2222 on the same edge → reg 7 = 0x2222_2222. With BYPASS=1 the read returns 0x2222_2222 in the same cycle; with BYPASS=0 it returns the old value until the edge.
- Zero register: write_a addr 0 = 0xFFFF_FFFF and reserve addr 0 → read 0 returns 0, read_busy 0, any_busy 0 (ZERO_REG=1). Repeat with ZERO_REG=0 → read returns 0xFFFF_FFFF and busy is set.
- Scoreboard life cycle: reserve addr 9 → read_busy_1=1 and any_busy=1 on the next cycle; write_b addr 9 = 0x1234 → busy clears after the edge. With BYPASS=1, read_busy_1=0 and read_data_1=0x1234 during the write cycle.
- Set/clear race: reserve addr 3 and write_a addr 3 = 0x55 on the same edge → reg 3 = 0x55 and busy[3]=1. A later write_b addr 3 clears it.
- Parameter sweep: DATA_WIDTH=64, ADDR_WIDTH=6 → write addr 63 = 0xDEAD_BEEF_CAFE_F00D, read back intact; write addr 0 and 63 together, each reads back its own value.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared constants and types for the MIPS register bank.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package regbank_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ZERO_ADDR      = 0;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/regbank_scoreboard.sv
// Per-register pending (busy) scoreboard; reserve sets, writeback clears.
// Latency: set/clear visible one edge later; read lookups are combinational.
// Backpressure: none, every request is accepted on the edge it is presented.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reserve,
  input  logic [ADDR_WIDTH-1:0] reserve_address,
  input  logic                  clear_a,
  input  logic [ADDR_WIDTH-1:0] clear_address_a,
  input  logic                  clear_b,
  input  logic [ADDR_WIDTH-1:0] clear_address_b,
  input  logic [ADDR_WIDTH-1:0] read_address_1,
  input  logic [ADDR_WIDTH-1:0] read_address_2,
  output logic                  busy_1,
  output logic                  busy_2,
  output logic                  any_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZADDR = ADDR_WIDTH'(ZERO_ADDR);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Reserve is applied after the clears so a new producer supersedes the retiring one.
  always_comb begin
    busy_d = busy_q;
    if (clear_a) busy_d[clear_address_a] = 1'b0;
    if (clear_b) busy_d[clear_address_b] = 1'b0;
    if (reserve && !(ZERO_REG && reserve_address == ZADDR)) busy_d[reserve_address] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_1   = busy_q[read_address_1];
  assign busy_2   = busy_q[read_address_2];
  assign any_busy = |busy_q;

endmodule

// File: rtl/register_bank_mp.sv
// Two-write/two-read register bank with optional bypass, zero register and busy scoreboard.
// Latency: reads combinational (same-cycle with BYPASS=1), writes land on the rising edge.
// Backpressure: none; port B wins a same-address write collision.
module register_bank_mp
  import regbank_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_a,
  input  logic [ADDR_WIDTH-1:0] write_address_a,
  input  logic [DATA_WIDTH-1:0] write_data_a,
  input  logic                  write_b,
  input  logic [ADDR_WIDTH-1:0] write_address_b,
  input  logic [DATA_WIDTH-1:0] write_data_b,
  input  logic                  reserve,
  input  logic [ADDR_WIDTH-1:0] reserve_address,
  input  logic [ADDR_WIDTH-1:0] read_address_1,
  input  logic [ADDR_WIDTH-1:0] read_address_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic                  read_busy_1,
  output logic                  read_busy_2,
  output logic                  any_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZADDR = ADDR_WIDTH'(ZERO_ADDR);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr_a;
  logic                  wr_b;
  logic                  raw_busy_1;
  logic                  raw_busy_2;

  // Writes to the hard-wired zero register are dropped before they reach storage or bypass.
  assign wr_a = write_a && !(ZERO_REG && write_address_a == ZADDR);
  assign wr_b = write_b && !(ZERO_REG && write_address_b == ZADDR);

  // Port B is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr_a) regs[write_address_a] <= write_data_a;
      if (wr_b) regs[write_address_b] <= write_data_b;
    end
  end

  regbank_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk             (clk),
    .rst_n           (rst_n),
    .reserve         (reserve),
    .reserve_address (reserve_address),
    .clear_a         (wr_a),
    .clear_address_a (write_address_a),
    .clear_b         (wr_b),
    .clear_address_b (write_address_b),
    .read_address_1  (read_address_1),
    .read_address_2  (read_address_2),
    .busy_1          (raw_busy_1),
    .busy_2          (raw_busy_2),
    .any_busy        (any_busy)
  );

  // Bypass is gated by rst_n so reads stay 0 throughout reset.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] v;
    v = regs[addr];
    if (BYPASS && rst_n) begin
      if (wr_a && write_address_a == addr) v = write_data_a;
      if (wr_b && write_address_b == addr) v = write_data_b;
    end
    if (ZERO_REG && addr == ZADDR) v = '0;
    return v;
  endfunction

  function automatic logic busy_masked(input logic [ADDR_WIDTH-1:0] addr, input logic raw);
    logic delivering;
    delivering = ((wr_a && write_address_a == addr) || (wr_b && write_address_b == addr))
                 && !(reserve && reserve_address == addr);
    return raw && !(BYPASS && rst_n && delivering);
  endfunction

  always_comb begin
    read_data_1 = read_port(read_address_1);
    read_data_2 = read_port(read_address_2);
    read_busy_1 = busy_masked(read_address_1, raw_busy_1);
    read_busy_2 = busy_masked(read_address_2, raw_busy_2);
  end

endmodule

// File: tb/tb_register_bank_mp.sv
// Bench for register_bank_mp: directed table, model-checked random traffic and reset/wide-config sequences.
module tb_register_bank_mp;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        write_a, write_b, reserve;
  logic [4:0]  waa, wab, ra, r1, r2;
  logic [31:0] da, db;

  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic        rb1_0, rb2_0, any_0, rb1_1, rb2_1, any_1;

  logic        w2_a, w2_b, w2_res;
  logic [5:0]  w2_aa, w2_ab, w2_ra, w2_r1, w2_r2;
  logic [63:0] w2_da, w2_db, d2_rd1, d2_rd2;
  logic        d2_b1, d2_b2, d2_any;

  // Config 0: BYPASS=1, ZERO_REG=1.
  register_bank_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .write_a(write_a), .write_address_a(waa), .write_data_a(da),
    .write_b(write_b), .write_address_b(wab), .write_data_b(db),
    .reserve(reserve), .reserve_address(ra),
    .read_address_1(r1), .read_address_2(r2),
    .read_data_1(rd1_0), .read_data_2(rd2_0),
    .read_busy_1(rb1_0), .read_busy_2(rb2_0), .any_busy(any_0));

  // Config 1: BYPASS=0, ZERO_REG=0.
  register_bank_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .write_a(write_a), .write_address_a(waa), .write_data_a(da),
    .write_b(write_b), .write_address_b(wab), .write_data_b(db),
    .reserve(reserve), .reserve_address(ra),
    .read_address_1(r1), .read_address_2(r2),
    .read_data_1(rd1_1), .read_data_2(rd2_1),
    .read_busy_1(rb1_1), .read_busy_2(rb2_1), .any_busy(any_1));

  register_bank_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(6), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .write_a(w2_a), .write_address_a(w2_aa), .write_data_a(w2_da),
    .write_b(w2_b), .write_address_b(w2_ab), .write_data_b(w2_db),
    .reserve(w2_res), .reserve_address(w2_ra),
    .read_address_1(w2_r1), .read_address_2(w2_r2),
    .read_data_1(d2_rd1), .read_data_2(d2_rd2),
    .read_busy_1(d2_b1), .read_busy_2(d2_b2), .any_busy(d2_any));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain arrays holding architectural register and pending state.
  logic [31:0] m_mem  [2][32];
  logic        m_busy [2][32];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 32; i++) begin
        m_mem[c][i]  = '0;
        m_busy[c][i] = 1'b0;
      end
  endfunction

  function automatic void model_update();
    for (int c = 0; c < 2; c++) begin
      bit zr = (c == 0);
      if (write_a && !(zr && waa == 0)) begin m_mem[c][waa] = da; m_busy[c][waa] = 1'b0; end
      if (write_b && !(zr && wab == 0)) begin m_mem[c][wab] = db; m_busy[c][wab] = 1'b0; end
      if (reserve && !(zr && ra == 0)) m_busy[c][ra] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] exp_rd(input int c, input logic [4:0] a);
    bit byp = (c == 0);
    bit zr  = (c == 0);
    if (!rst_n) return '0;
    if (zr && a == 0) return '0;
    if (byp && write_b && wab == a) return db;
    if (byp && write_a && waa == a) return da;
    return m_mem[c][a];
  endfunction

  function automatic logic exp_busy(input int c, input logic [4:0] a);
    bit byp = (c == 0);
    if (!rst_n) return 1'b0;
    if (byp && ((write_a && waa == a) || (write_b && wab == a)) && !(reserve && ra == a)) return 1'b0;
    return m_busy[c][a];
  endfunction

  function automatic logic exp_any(input int c);
    logic o = 1'b0;
    for (int i = 0; i < 32; i++) o |= m_busy[c][i];
    return o;
  endfunction

  task automatic model_check(input int c, input logic [31:0] a1, input logic [31:0] a2,
                             input logic b1, input logic b2, input logic an);
    check($sformatf("c%0d_rd1", c), 64'(a1), 64'(exp_rd(c, r1)));
    check($sformatf("c%0d_rd2", c), 64'(a2), 64'(exp_rd(c, r2)));
    check($sformatf("c%0d_busy1", c), 64'(b1), 64'(exp_busy(c, r1)));
    check($sformatf("c%0d_busy2", c), 64'(b2), 64'(exp_busy(c, r2)));
    check($sformatf("c%0d_any", c), 64'(an), 64'(exp_any(c)));
  endtask

  // Called right after a falling edge with inputs already driven.
  task automatic tick(input bit chk0);
    #2;
    if (chk0) model_check(0, rd1_0, rd2_0, rb1_0, rb2_0, any_0);
    model_check(1, rd1_1, rd2_1, rb1_1, rb2_1, any_1);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    write_a = 0; waa = '0; da = '0;
    write_b = 0; wab = '0; db = '0;
    reserve = 0; ra = '0;
  endtask

  typedef struct {
    logic wa; logic [4:0] waa; logic [31:0] da;
    logic wb; logic [4:0] wab; logic [31:0] db;
    logic res; logic [4:0] ra;
    logic [4:0] r1; logic [4:0] r2;
    logic [31:0] e_rd1; logic [31:0] e_rd2;
    logic e_b1; logic e_b2; logic e_any;
  } vec_t;

  vec_t vecs[18];

  initial begin
    // Expected values are for config 0 (bypass on, zero register on), applied from reset.
    vecs[0]  = '{T, 5'd5, 32'hAA,       F, 5'd0, 32'h0,        F, 5'd0, 5'd5, 5'd0, 32'hAA,       32'h0,        F, F, F};
    vecs[1]  = '{F, 5'd0, 32'h0,        F, 5'd0, 32'h0,        F, 5'd0, 5'd5, 5'd7, 32'hAA,       32'h0,        F, F, F};
    vecs[2]  = '{T, 5'd7, 32'h11111111, T, 5'd7, 32'h22222222, F, 5'd0, 5'd7, 5'd5, 32'h22222222, 32'hAA,       F, F, F};
    vecs[3]  = '{F, 5'd0, 32'h0,        F, 5'd0, 32'h0,        F, 5'd0, 5'd7, 5'd7, 32'h22222222, 32'h22222222, F, F, F};
    vecs[4]  = '{T, 5'd0, 32'hFFFFFFFF, F, 5'd0, 32'h0,        T, 5'd0, 5'd0, 5'd7, 32'h0,        32'h22222222, F, F, F};
    vecs[5]  = '{F, 5'd0, 32'h0,        F, 5'd0, 32'h0,        F, 5'd0, 5'd0, 5'd5, 32'h0,        32'hAA,       F, F, F};
    vecs[6]  = '{F, 5'd0, 32'h0,        F, 5'd0, 32'h0,        T, 5'd9, 5'd9, 5'd0, 32'h0,        32'h0,        F, F, F};
    vecs[7]  = '{F, 5'd0, 32'h0,        F, 5'd0, 32'h0,        F, 5'd0, 5'd9, 5'd9, 32'h0,        32'h0,        T, T, T};
    vecs[8]  = '{F, 5'd0, 32'h0,        T, 5'd9, 32'h1234,     F, 5'd0, 5'd9, 5'd5, 32'h1234,     32'hAA,       F, F, T};
    vecs[9]  = '{F, 5'd0, 32'h0,        F, 5'd0, 32'h0,        F, 5'd0, 5'd9, 5'd9, 32'h1234,     32'h1234,     F, F, F};
    vecs[10] = '{T, 5'd3, 32'h55,       F, 5'd0, 32'h0,        T, 5'd3, 5'd3, 5'd9, 32'h55,       32'h1234,     F, F, F};
    vecs[11] = '{F, 5'd0, 32'h0,        F, 5'd0, 32'h0,        F, 5'd0, 5'd3, 5'd3, 32'h55,       32'h55,       T, T, T};
    vecs[12] = '{F, 5'd0, 32'h0,        T, 5'd3, 32'h66,       F, 5'd0, 5'd3, 5'd3, 32'h66,       32'h66,       F, F, T};
    vecs[13] = '{F, 5'd0, 32'h0,        F, 5'd0, 32'h0,        F, 5'd0, 5'd3, 5'd0, 32'h66,       32'h0,        F, F, F};
    vecs[14] = '{F, 5'd0, 32'h0,        F, 5'd0, 32'h0,        T, 5'd4, 5'd4, 5'd0, 32'h0,        32'h0,        F, F, F};
    vecs[15] = '{F, 5'd0, 32'h0,        F, 5'd0, 32'h0,        T, 5'd4, 5'd4, 5'd0, 32'h0,        32'h0,        T, F, T};
    vecs[16] = '{T, 5'd4, 32'h7,        F, 5'd0, 32'h0,        F, 5'd0, 5'd4, 5'd0, 32'h7,        32'h0,        F, F, T};
    vecs[17] = '{F, 5'd0, 32'h0,        F, 5'd0, 32'h0,        F, 5'd0, 5'd4, 5'd0, 32'h7,        32'h0,        F, F, F};

    model_reset();
    rst_n = 1'b0;
    idle();
    r1 = 5'd5; r2 = 5'd0;
    w2_a = 0; w2_aa = '0; w2_da = '0; w2_b = 0; w2_ab = '0; w2_db = '0;
    w2_res = 0; w2_ra = '0; w2_r1 = 6'd63; w2_r2 = 6'd0;

    // Reset state, with a write presented that must not bypass while in reset.
    #2;
    write_a = 1; waa = 5'd5; da = 32'hDEAD0001;
    w2_a = 1; w2_aa = 6'd63; w2_da = 64'h1;
    #1;
    check("rst_rd1_c0", 64'(rd1_0), 64'h0);
    check("rst_busy1_c0", 64'(rb1_0), 64'h0);
    check("rst_any_c0", 64'(any_0), 64'h0);
    check("rst_rd1_c1", 64'(rd1_1), 64'h0);
    check("rst_rd1_w64", d2_rd1, 64'h0);
    @(negedge clk);
    idle();
    w2_a = 0; w2_aa = '0; w2_da = '0;
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[i]) begin
      write_a = vecs[i].wa; waa = vecs[i].waa; da = vecs[i].da;
      write_b = vecs[i].wb; wab = vecs[i].wab; db = vecs[i].db;
      reserve = vecs[i].res; ra = vecs[i].ra;
      r1 = vecs[i].r1; r2 = vecs[i].r2;
      #1;
      check($sformatf("vec%0d_rd1", i), 64'(rd1_0), 64'(vecs[i].e_rd1));
      check($sformatf("vec%0d_rd2", i), 64'(rd2_0), 64'(vecs[i].e_rd2));
      check($sformatf("vec%0d_busy1", i), 64'(rb1_0), 64'(vecs[i].e_b1));
      check($sformatf("vec%0d_busy2", i), 64'(rb2_0), 64'(vecs[i].e_b2));
      check($sformatf("vec%0d_any", i), 64'(any_0), 64'(vecs[i].e_any));
      tick(1'b0);
    end

    // Randomised traffic on a narrow address window to force collisions and races.
    for (int n = 0; n < 300; n++) begin
      write_a = 1'($urandom_range(0, 1)); waa = 5'($urandom_range(0, 7)); da = $urandom;
      write_b = 1'($urandom_range(0, 1)); wab = 5'($urandom_range(0, 7)); db = $urandom;
      reserve = 1'($urandom_range(0, 1)); ra = 5'($urandom_range(0, 7));
      r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
      tick(1'b1);
    end

    // Mid-cycle reset with a write and reserve presented during reset.
    idle();
    write_a = 1; waa = 5'd2; da = 32'h77; reserve = 1; ra = 5'd2; r1 = 5'd2; r2 = 5'd3;
    tick(1'b1);
    idle();
    #2;
    rst_n = 1'b0;
    write_a = 1; waa = 5'd2; da = 32'hCAFE; reserve = 1; ra = 5'd3;
    #1;
    check("midrst_rd1_c0", 64'(rd1_0), 64'h0);
    check("midrst_rd1_c1", 64'(rd1_1), 64'h0);
    check("midrst_busy1_c1", 64'(rb1_1), 64'h0);
    check("midrst_any_c0", 64'(any_0), 64'h0);
    check("midrst_any_c1", 64'(any_1), 64'h0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    idle();
    rst_n = 1'b1;
    r1 = 5'd2; r2 = 5'd3;
    tick(1'b1);

    // Wide configuration: 64-bit data, 64 registers, address 0 ordinary.
    w2_a = 1; w2_aa = 6'd63; w2_da = 64'hDEADBEEFCAFEF00D;
    w2_b = 1; w2_ab = 6'd0;  w2_db = 64'h0123456789ABCDEF;
    w2_r1 = 6'd63; w2_r2 = 6'd0;
    #2;
    check("w64_byp_rd1", d2_rd1, 64'hDEADBEEFCAFEF00D);
    check("w64_byp_rd2", d2_rd2, 64'h0123456789ABCDEF);
    @(negedge clk);
    w2_a = 1; w2_aa = 6'd62; w2_da = 64'h1;
    w2_b = 0;
    #2;
    check("w64_rd63", d2_rd1, 64'hDEADBEEFCAFEF00D);
    check("w64_rd0", d2_rd2, 64'h0123456789ABCDEF);
    @(negedge clk);
    w2_a = 0;
    w2_r2 = 6'd62;
    #2;
    check("w64_rd63_after", d2_rd1, 64'hDEADBEEFCAFEF00D);
    check("w64_rd62", d2_rd2, 64'h1);
    check("w64_any", 64'(d2_any), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
